// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding memory read, one-entry output buffer.
// Redirects override sequential PC advance and squash any in-flight fetch.
module ifu_fetch #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned PC_STEP  = 4,
   parameter logic [31:0] CNT_INIT = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_rdata,
   output logic            pc_wen,
   output logic [XLEN-1:0] pc_wdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            rsp_valid,
   input  logic [XLEN-1:0] rsp_data,
   input  logic            rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   output logic [31:0]     fetch_cnt
);

   typedef enum logic [1:0] {S_REQ, S_RSP, S_OUT} state_t;

   state_t          state_q, state_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] inst_data_q, inst_pc_q;
   logic            inst_err_q;
   logic [31:0]     cnt_q;
   logic            req_fire, rsp_take, inst_fire;

   assign req_addr  = pc_rdata;
   assign inst_data = inst_data_q;
   assign inst_pc   = inst_pc_q;
   assign inst_err  = inst_err_q;
   assign fetch_cnt = cnt_q;

   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      req_valid = 1'b0;
      inst_valid = 1'b0;
      pc_wen    = 1'b0;
      pc_wdata  = '0;
      req_fire  = 1'b0;
      rsp_take  = 1'b0;
      inst_fire = 1'b0;
      if (!reset) begin
         if (redirect_valid) begin
            pc_wen   = 1'b1;
            pc_wdata = redirect_pc;
         end
         case (state_q)
            S_REQ: begin
               req_valid = !redirect_valid;
               if (req_valid && req_ready) begin
                  req_fire = 1'b1;
                  state_d  = S_RSP;
               end
            end
            S_RSP: begin
               // A redirect seen before the response arrives poisons that response.
               if (rsp_valid) begin
                  drop_d = 1'b0;
                  if (drop_q || redirect_valid) begin
                     state_d = S_REQ;
                  end else begin
                     rsp_take = 1'b1;
                     state_d  = S_OUT;
                  end
               end else if (redirect_valid) begin
                  drop_d = 1'b1;
               end
            end
            S_OUT: begin
               inst_valid = !redirect_valid;
               if (redirect_valid) begin
                  state_d = S_REQ;
               end else if (inst_ready) begin
                  inst_fire = 1'b1;
                  pc_wen    = 1'b1;
                  pc_wdata  = inst_pc_q + XLEN'(PC_STEP);
                  state_d   = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_REQ;
         drop_q      <= 1'b0;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
         inst_err_q  <= 1'b0;
         cnt_q       <= CNT_INIT;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (req_fire) inst_pc_q <= pc_rdata;
         if (rsp_take) begin
            inst_data_q <= rsp_data;
            inst_err_q  <= rsp_err;
         end
         if (inst_fire) cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: transaction-level model checked every cycle plus literal pins.
module tb_ifu_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_rdata = 32'h3000_0000;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        rsp_err = 1'b0;
   logic        inst_ready = 1'b0;

   logic        pc_wen, req_valid, inst_valid, inst_err;
   logic [31:0] pc_wdata, req_addr, inst_data, inst_pc, fetch_cnt;
   logic        w_pc_wen, w_req_valid, w_inst_valid, w_inst_err;
   logic [31:0] w_pc_wdata, w_req_addr, w_inst_data, w_inst_pc, w_fetch_cnt;

   int n_chk = 0;
   int n_fail = 0;

   logic        last_wen, last_req_valid;
   logic [31:0] last_wdata, last_req_addr;

   ifu_fetch #(.XLEN(32), .PC_STEP(4)) dut (
      .clock(clock), .reset(reset), .pc_rdata(pc_rdata), .pc_wen(pc_wen), .pc_wdata(pc_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_err(inst_err), .fetch_cnt(fetch_cnt)
   );

   // Second instance with the counter preset to all-ones to exercise wraparound.
   ifu_fetch #(.XLEN(32), .PC_STEP(4), .CNT_INIT(32'hFFFF_FFFF)) dut_w (
      .clock(clock), .reset(reset), .pc_rdata(pc_rdata), .pc_wen(w_pc_wen), .pc_wdata(w_pc_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .req_valid(w_req_valid), .req_ready(req_ready), .req_addr(w_req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst_data(w_inst_data),
      .inst_pc(w_inst_pc), .inst_err(w_inst_err), .fetch_cnt(w_fetch_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a fetch is either in flight (possibly poisoned) or buffered, never both.
   initial begin
      logic        m_inflight, m_poison, m_buffered, m_err;
      logic [31:0] m_pc, m_data, m_cnt;
      logic        e_req, e_inst, e_wen;
      logic [31:0] e_wdata;
      m_inflight = 0; m_poison = 0; m_buffered = 0; m_err = 0;
      m_pc = 0; m_data = 0; m_cnt = 0;
      @(posedge clock);
      forever begin
         @(negedge clock);
         e_req   = !reset && !m_inflight && !m_buffered && !redirect_valid;
         e_inst  = !reset && m_buffered && !redirect_valid;
         e_wen   = !reset && (redirect_valid || (m_buffered && inst_ready));
         e_wdata = redirect_valid ? redirect_pc : m_pc + 32'd4;
         chk("req_valid", {31'b0, req_valid}, {31'b0, e_req});
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_inst});
         chk("pc_wen", {31'b0, pc_wen}, {31'b0, e_wen});
         if (e_wen) chk("pc_wdata", pc_wdata, e_wdata);
         if (e_req) chk("req_addr", req_addr, pc_rdata);
         chk("inst_pc", inst_pc, m_pc);
         chk("inst_data", inst_data, m_data);
         chk("inst_err", {31'b0, inst_err}, {31'b0, m_err});
         chk("fetch_cnt", fetch_cnt, m_cnt);
         chk("w_req_valid", {31'b0, w_req_valid}, {31'b0, e_req});
         chk("w_inst_valid", {31'b0, w_inst_valid}, {31'b0, e_inst});
         chk("w_pc_wen", {31'b0, w_pc_wen}, {31'b0, e_wen});
         if (e_wen) chk("w_pc_wdata", w_pc_wdata, e_wdata);
         if (e_req) chk("w_req_addr", w_req_addr, pc_rdata);
         chk("w_inst_pc", w_inst_pc, m_pc);
         chk("w_inst_data", w_inst_data, m_data);
         chk("w_inst_err", {31'b0, w_inst_err}, {31'b0, m_err});
         chk("w_fetch_cnt", w_fetch_cnt, m_cnt + 32'hFFFF_FFFF);
         // Advance the model to what the coming rising edge produces.
         if (reset) begin
            m_inflight = 0; m_poison = 0; m_buffered = 0; m_err = 0;
            m_pc = 0; m_data = 0; m_cnt = 0;
         end else if (e_req && req_ready) begin
            m_inflight = 1;
            m_pc = pc_rdata;
         end else if (m_inflight && rsp_valid) begin
            m_inflight = 0;
            if (!m_poison && !redirect_valid) begin
               m_buffered = 1;
               m_data = rsp_data;
               m_err = rsp_err;
            end
            m_poison = 0;
         end else if (m_inflight && redirect_valid) begin
            m_poison = 1;
         end else if (m_buffered && (redirect_valid || inst_ready)) begin
            m_buffered = 0;
            if (!redirect_valid) m_cnt = m_cnt + 32'd1;
         end
      end
   end

   // One clock of stimulus; the bench's PC register follows pc_wen.
   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic rspv, input logic [31:0] rdata, input logic rerr, input logic irdy);
      redirect_valid = rv; redirect_pc = rpc; req_ready = rdy;
      rsp_valid = rspv; rsp_data = rdata; rsp_err = rerr; inst_ready = irdy;
      @(negedge clock);
      last_wen = pc_wen; last_wdata = pc_wdata;
      last_req_valid = req_valid; last_req_addr = req_addr;
      @(posedge clock);
      #1;
      if (last_wen) pc_rdata = last_wdata;
   endtask

   initial begin
      @(posedge clock);
      #1;
      // Reset, with redirect and a response strobe present to prove they are ignored.
      cyc(1, 32'h1234_5678, 1, 1, 32'hAAAA_AAAA, 1, 1);
      chk("rst_pc_wen", {31'b0, last_wen}, 32'd0);
      chk("rst_req_valid", {31'b0, last_req_valid}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_w_fetch_cnt", w_fetch_cnt, 32'hFFFF_FFFF);
      reset = 0;

      // Basic fetch and accept.
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("b_req_valid", {31'b0, last_req_valid}, 32'd1);
      chk("b_req_addr", last_req_addr, 32'h3000_0000);
      chk("b_inst_pc", inst_pc, 32'h3000_0000);
      cyc(0, 0, 1, 1, 32'h0000_0013, 0, 1);
      chk("b_inst_data", inst_data, 32'h0000_0013);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("b_pc_wdata", last_wdata, 32'h3000_0004);
      chk("b_fetch_cnt", fetch_cnt, 32'd1);
      chk("wrap_fetch_cnt", w_fetch_cnt, 32'd0);

      // Downstream stall for five cycles.
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 32'h0010_0093, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 0, 0, 0, 0);
         chk("stall_pc_wen", {31'b0, last_wen}, 32'd0);
         chk("stall_req_valid", {31'b0, last_req_valid}, 32'd0);
         chk("stall_inst_pc", inst_pc, 32'h3000_0004);
      end
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("stall_pc_wdata", last_wdata, 32'h3000_0008);

      // Bus error is delivered and advances normally.
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0);
      chk("err_inst_err", {31'b0, inst_err}, 32'd1);
      chk("err_inst_pc", inst_pc, 32'h3000_0008);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("err_pc_wdata", last_wdata, 32'h3000_000C);
      chk("err_fetch_cnt", fetch_cnt, 32'd3);

      // Redirect while waiting for a response, twice, then the stale response.
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 32'h3000_0100, 1, 0, 0, 0, 1);
      chk("drop_pc_wdata", last_wdata, 32'h3000_0100);
      cyc(1, 32'h3000_0100, 1, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 32'h0000_0BAD, 0, 1);
      chk("drop_fetch_cnt", fetch_cnt, 32'd3);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("drop_req_addr", last_req_addr, 32'h3000_0100);
      cyc(0, 0, 1, 1, 32'h0000_0013, 0, 0);

      // Redirect and accept in the same cycle: redirect wins, no count.
      cyc(1, 32'h3000_0200, 1, 0, 0, 0, 1);
      chk("race_pc_wdata", last_wdata, 32'h3000_0200);
      chk("race_fetch_cnt", fetch_cnt, 32'd3);

      // Redirect in request state suppresses the handshake.
      cyc(1, 32'h3000_0300, 1, 0, 0, 0, 0);
      chk("rq_redir_req_valid", {31'b0, last_req_valid}, 32'd0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("rq_redir_req_addr", last_req_addr, 32'h3000_0300);

      // Response and redirect together: response discarded.
      cyc(1, 32'hFFFF_FFFC, 1, 1, 32'h1111_1111, 0, 0);

      // PC wraparound on accept.
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 32'h0000_0013, 0, 0);
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("wrap_pc_wdata", last_wdata, 32'h0000_0000);
      chk("wrap_pc_wen", {31'b0, last_wen}, 32'd1);

      // Reset mid-transaction, then a late response that must be ignored.
      cyc(0, 0, 1, 0, 0, 0, 0);
      reset = 1;
      cyc(0, 0, 0, 0, 0, 0, 0);
      reset = 0;
      chk("mid_rst_fetch_cnt", fetch_cnt, 32'd0);
      cyc(0, 0, 0, 1, 32'h5555_5555, 1, 0);
      chk("late_rsp_req_valid", {31'b0, last_req_valid}, 32'd1);
      chk("late_rsp_inst_data", inst_data, 32'd0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
